// File: rtl/pc_flag_unit_pkg.sv
// Shared types for the sequencer stage: branch condition codes and control FSM states.
package pc_flag_unit_pkg;

    typedef enum logic [1:0] {
        ALWAYS = 2'b00,
        EQ     = 2'b01,
        LT     = 2'b10,
        CS     = 2'b11
    } cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pcstate_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: checks the selected condition against the registered flags.
module branch_cond
    import pc_flag_unit_pkg::*;
(
    input  cond_t Cond,
    input  logic  FlagZ,
    input  logic  FlagN,
    input  logic  FlagC,
    output logic  cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (Cond)
            ALWAYS:  cond_true = 1'b1;
            EQ:      cond_true = FlagZ;
            LT:      cond_true = FlagN;
            CS:      cond_true = FlagC;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// Sequencer stage after the ALU: flag register with carry feedback, branch resolution,
// program counter and the IDLE/RUN/HALT control FSM.
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter int unsigned PW = 10,
    parameter int unsigned OW = 6
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          FlagWe,
    input  logic          Zero,
    input  logic          Neg,
    input  logic          SC_out,
    input  logic          CarryClr,
    input  logic          Branch,
    input  cond_t         Cond,
    input  logic          BrRel,
    input  logic [PW-1:0] Target,
    input  logic          Halt,
    output logic [PW-1:0] PC,
    output logic          SC_in,
    output logic          FlagZ,
    output logic          FlagN,
    output logic          FlagC,
    output logic          Taken,
    output logic          Running,
    output logic          Done
);

    pcstate_t      state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic          z_q, z_d;
    logic          n_q, n_d;
    logic          c_q, c_d;
    logic          cond_true;
    logic [PW-1:0] offset;

    branch_cond u_branch_cond (
        .Cond      (Cond),
        .FlagZ     (z_q),
        .FlagN     (n_q),
        .FlagC     (c_q),
        .cond_true (cond_true)
    );

    // Sign-extend the short relative offset; upper Target bits are ignored in relative mode.
    assign offset = {{(PW-OW){Target[OW-1]}}, Target[OW-1:0]};

    // Condition sees the flags as registered before any same-cycle FlagWe lands.
    assign Taken = (state_q == RUN) && Branch && cond_true && !Halt;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;

        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    z_d     = 1'b0;
                    n_d     = 1'b0;
                    c_d     = 1'b0;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (Taken) begin
                    pc_d = BrRel ? PW'(pc_q + offset) : Target;
                end else begin
                    pc_d = PW'(pc_q + PW'(1));
                end

                if (FlagWe) begin
                    z_d = Zero;
                    n_d = Neg;
                    c_d = SC_out;
                end
                if (CarryClr) begin
                    c_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
        end
    end

    assign PC      = pc_q;
    assign FlagZ   = z_q;
    assign FlagN   = n_q;
    assign FlagC   = c_q;
    assign SC_in   = c_q;
    assign Running = (state_q == RUN);
    assign Done    = (state_q == HALT);

endmodule
